ps2_scancode_decoder: RTL
=========================

// Module: ps2_scancode_decoder
// PURPOSE
// - Sits between PS2_Controller and system: consumes raw set-2 bytes (received_data/_en).
// - Tracks E0/F0/E1 prefixes; emits one event per complete make/break code.
// - Buffers events in a small FIFO with valid/ready to system; maintains debug keycode/make/ext and held-arrow move code.
// PARAMETERS
// - FIFO_DEPTH   4      event FIFO entries, power of 2, >=2
// - TIMEOUT_CYC  50000  cycles with no byte before a partial prefix sequence is abandoned (1 ms @ 50 MHz)
// - PAUSE_SKIP   7      bytes discarded after E1 (Pause sequence)
// PORTS
// - clk          in   1  50 MHz system clock
// - resetn       in   1  async active-low reset
// - key_en       in   1  1-cycle strobe, key_data valid
// - key_data     in   8  raw PS/2 byte
// - evt_valid    out  1  FIFO head valid
// - evt_ready    in   1  consumer accepts head this cycle
// - evt_code     out  8  head scancode (prefixes stripped)
// - evt_make     out  1  head: 1=make, 0=break
// - evt_ext      out  1  head: E0-prefixed
// - keycode      out  8  last completed code (debug/HEX)
// - key_make     out  1  last completed code was make
// - key_ext      out  1  last completed code was extended
// - move         out  3  held action: 0 none,1 up,2 down,3 left,4 right,5 space
// - overflow     out  1  sticky: event dropped because FIFO full
// BEHAVIOUR
// - Reset (async, resetn=0): FSM=IDLE, FIFO empty, evt_valid=0, evt_code/make/ext=0, keycode=0,
//   key_make=0, key_ext=0, move=0, overflow=0, timeout and skip counters=0. Bytes arriving mid-reset are lost.
// - FSM advances only on key_en=1:
//   - IDLE: E0->EXT; F0->BRK; E1->SKIP (cnt=PAUSE_SKIP); 00,AA,EE,FA,FE,FF ignored; else emit make(code,ext=0).
//   - EXT: F0->EXT_BRK; E0 stays EXT; 12/59 (fake shift) ->IDLE, no event; else emit make(code,ext=1)->IDLE.
//   - BRK: emit break(code,ext=0)->IDLE.
//   - EXT_BRK: 12/59 ->IDLE, no event; else emit break(code,ext=1)->IDLE.
//   - SKIP: decrement cnt each byte; ->IDLE when cnt reaches 0; no events.
// - Timeout: in EXT/BRK/EXT_BRK/SKIP, counter increments each clk without key_en and clears on key_en.
//   At TIMEOUT_CYC, FSM->IDLE; no event emitted.
// - Emit (cycle n = key_en of final byte): at n+1 keycode/key_make/key_ext updated, FIFO push visible
//   (evt_valid=1 if it was empty), move updated. Latency 1 cycle; autorepeat makes each emit a new event.
// - FIFO: show-ahead; evt_* = head. Pop when evt_valid & evt_ready; evt_ready ignored when empty.
//   - Full, push without pop: event dropped; overflow<=1, clears only on reset.
//   - Full, push with pop: both happen, no drop. Empty, push: evt_valid=1 next cycle.
//   - Pointers are log2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH. Full = MSBs differ, rest equal.
// - move mapping (ext=1): 75 up, 72 down, 6B left, 74 right; (ext=0): 29 space.
//   - Make of a mapped key: move<=its code (most recent wins).
//   - Break of a mapped key: move<=0 only if it equals current move; else unchanged.
//   - Unmapped codes never alter move.
// - keycode/key_make/key_ext and move update even when the FIFO event is dropped.
// STRUCTURE
// - Include ps2_codes.vh: byte constants (PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, ack/BAT set).
// - Include ps2_codes.vh: arrow/space codes, MOVE_* 3-bit encodings, FSM state localparams.
// - Sub-module ps2_event_fifo: width 10 {ext,make,code}, parameter DEPTH, push/pop/full/empty, show-ahead.
// - Top holds FSM, timeout and skip counters, last-code registers, and the move register.
// TESTING
// - 1C: evt 1C/make/ext0, keycode=1C next clk. F0 1C: break event. move stays 0.
// - E0 75: move=1, evt 75/make/ext1. E0 6B: move=3. E0 F0 75: move=3. E0 F0 6B: move=0.
// - evt_ready=0, send 5 makes 15,1D,24,2D,2C (DEPTH 4): overflow=1; pops yield 15,1D,24,2D, then valid=0.
// - Full FIFO, evt_ready=1, push same clk: no drop, overflow=0, order preserved.
// - E0 then 50000 idle clks, then 75: make 75 ext0, move=0. E1 14 77 E1 F0 14 F0 77 then 29: only space make, move=5.
// - Assert resetn mid E0 F0 sequence: all outputs 0 asynchronously. Next 1C: plain make.

Source files
------------

// File: rtl/ps2_scancode_decoder_pkg.sv
// ps2_scancode_decoder_pkg: PS/2 set-2 byte constants, FSM encodings, event type and key mapping helpers.
package ps2_scancode_decoder_pkg;
    localparam logic [7:0] PS2_EXT     = 8'hE0;
    localparam logic [7:0] PS2_BRK     = 8'hF0;
    localparam logic [7:0] PS2_PAUSE   = 8'hE1;
    localparam logic [7:0] KEY_UP      = 8'h75;
    localparam logic [7:0] KEY_DOWN    = 8'h72;
    localparam logic [7:0] KEY_LEFT    = 8'h6B;
    localparam logic [7:0] KEY_RIGHT   = 8'h74;
    localparam logic [7:0] KEY_SPACE   = 8'h29;
    localparam logic [7:0] FAKE_LSHIFT = 8'h12;
    localparam logic [7:0] FAKE_RSHIFT = 8'h59;
    localparam logic [2:0] MOVE_NONE   = 3'd0;
    localparam logic [2:0] MOVE_UP     = 3'd1;
    localparam logic [2:0] MOVE_DOWN   = 3'd2;
    localparam logic [2:0] MOVE_LEFT   = 3'd3;
    localparam logic [2:0] MOVE_RIGHT  = 3'd4;
    localparam logic [2:0] MOVE_SPACE  = 3'd5;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_EXT      = 3'd1;
    localparam logic [2:0] ST_BRK      = 3'd2;
    localparam logic [2:0] ST_EXT_BRK  = 3'd3;
    localparam logic [2:0] ST_SKIP     = 3'd4;
    typedef struct packed {
        logic       ext;
        logic       make;
        logic [7:0] code;
    } evt_t;
    // Keyboard housekeeping bytes (ack, BAT, echo, resend, errors) carry no key.
    function automatic logic is_ack(input logic [7:0] b);
        return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF;
    endfunction
    function automatic logic is_fake_shift(input logic [7:0] b);
        return b == FAKE_LSHIFT || b == FAKE_RSHIFT;
    endfunction
    function automatic logic [2:0] move_of(input logic [7:0] c, input logic ext);
        return ext ? (c == KEY_UP    ? MOVE_UP    :
                      c == KEY_DOWN  ? MOVE_DOWN  :
                      c == KEY_LEFT  ? MOVE_LEFT  :
                      c == KEY_RIGHT ? MOVE_RIGHT : MOVE_NONE)
                   : (c == KEY_SPACE ? MOVE_SPACE : MOVE_NONE);
    endfunction
endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: raw byte input strobe and valid/ready event stream toward the system.
interface ps2_scancode_decoder_if;
    logic       key_en;
    logic [7:0] key_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_make;
    logic       evt_ext;
    modport slave (input key_en, key_data, evt_ready, output evt_valid, evt_code, evt_make, evt_ext);
    modport master (output key_en, key_data, evt_ready, input evt_valid, evt_code, evt_make, evt_ext);
endinterface

// File: rtl/ps2_scancode_decoder_fifo.sv
// ps2_event_fifo: show-ahead event FIFO with extra-MSB pointers; head reads as zero when empty.
module ps2_event_fifo
    import ps2_scancode_decoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push_i,
    input  evt_t din_i,
    input  logic pop_i,
    output evt_t dout_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);
    evt_t           mem_q [DEPTH];
    logic [AW:0]    wr_q, wr_d, rd_q, rd_d;
    logic           do_push, do_pop;
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot the push lands in, so full+pop+push loses nothing.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
    always_comb begin
        wr_d = do_push ? wr_q + 1'b1 : wr_q;
        rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: turns raw PS/2 set-2 bytes into make/break events, queued in a FIFO,
// plus last-code debug registers and the currently held movement key.
module ps2_scancode_decoder
    import ps2_scancode_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int PAUSE_SKIP  = 7
) (
    input  logic                    clk,
    input  logic                    resetn,
    ps2_scancode_decoder_if.slave   bus,
    output logic [7:0]              keycode,
    output logic                    key_make,
    output logic                    key_ext,
    output logic [2:0]              move,
    output logic                    overflow
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int SW = $clog2(PAUSE_SKIP + 1);
    logic [2:0]  state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [SW-1:0] skip_q, skip_d;
    logic [7:0]  keycode_q, keycode_d;
    logic        key_make_q, key_make_d, key_ext_q, key_ext_d;
    logic [2:0]  move_q, move_d, mv;
    logic        overflow_q, overflow_d;
    logic        emit, emit_make, emit_ext, full, empty, pop;
    logic [7:0]  d;
    evt_t        head;
    assign d = bus.key_data;
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        skip_d    = skip_q;
        emit      = 1'b0;
        emit_make = 1'b1;
        emit_ext  = 1'b0;
        if (bus.key_en) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (d == PS2_EXT) state_d = ST_EXT;
                    else if (d == PS2_BRK) state_d = ST_BRK;
                    else if (d == PS2_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = SW'(PAUSE_SKIP);
                    end else emit = !is_ack(d);
                end
                ST_EXT: begin
                    if (d == PS2_BRK) state_d = ST_EXT_BRK;
                    else if (d != PS2_EXT) begin
                        state_d  = ST_IDLE;
                        emit     = !is_fake_shift(d);
                        emit_ext = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_d   = ST_IDLE;
                    emit      = 1'b1;
                    emit_make = 1'b0;
                end
                ST_EXT_BRK: begin
                    state_d   = ST_IDLE;
                    emit      = !is_fake_shift(d);
                    emit_make = 1'b0;
                    emit_ext  = 1'b1;
                end
                ST_SKIP: begin
                    skip_d  = skip_q - 1'b1;
                    state_d = skip_q <= SW'(1) ? ST_IDLE : ST_SKIP;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            // A stalled prefix sequence is abandoned so a lost byte cannot wedge the decoder.
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TW'(TIMEOUT_CYC)) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end
        end
    end
    always_comb begin
        mv         = move_of(d, emit_ext);
        keycode_d  = emit ? d : keycode_q;
        key_make_d = emit ? emit_make : key_make_q;
        key_ext_d  = emit ? emit_ext : key_ext_q;
        move_d     = move_q;
        if (emit && mv != MOVE_NONE)
            move_d = emit_make ? mv : (mv == move_q ? MOVE_NONE : move_q);
        overflow_d = overflow_q || (emit && full && !pop);
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            skip_q     <= '0;
            keycode_q  <= '0;
            key_make_q <= 1'b0;
            key_ext_q  <= 1'b0;
            move_q     <= MOVE_NONE;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            skip_q     <= skip_d;
            keycode_q  <= keycode_d;
            key_make_q <= key_make_d;
            key_ext_q  <= key_ext_d;
            move_q     <= move_d;
            overflow_q <= overflow_d;
        end
    end
    assign pop = !empty && bus.evt_ready;
    ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (emit),
        .din_i   ('{ext: emit_ext, make: emit_make, code: d}),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );
    assign bus.evt_valid = !empty;
    assign bus.evt_code  = head.code;
    assign bus.evt_make  = head.make;
    assign bus.evt_ext   = head.ext;
    assign keycode       = keycode_q;
    assign key_make      = key_make_q;
    assign key_ext       = key_ext_q;
    assign move          = move_q;
    assign overflow      = overflow_q;
endmodule
